mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-side partner of the microprogrammed control unit.
- Consumes the MOV, R/W and DS1-DS0 fields of the control word, plus the MAR address and the MDR write data.
- Performs a byte, halfword or word access to an internal byte-addressed RAM after a fixed number of wait states.
- Returns MOC (memory operation complete), which the control unit tests through its condition mux to hold or advance the microprogram.

Parameters:
- ADDR_BITS, 8, RAM holds 2^ADDR_BITS bytes; address bits above this are ignored, so addresses wrap.
- WAIT_STATES, 2, number of idle cycles between MOV acceptance and the access cycle (0 allowed).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous reset, active-high.
- MOV  in  1  memory operation valid, request level from the control word.
- RW  in  1  1 = read, 0 = write.
- DS  in  2  data size: 00 byte, 01 halfword, 10 word, 11 reserved.
- ADDR  in  32  byte address from MAR.
- DATA_IN  in  32  write data from MDR; byte in [7:0], halfword in [15:0].
- DATA_OUT  out  32  read data to MDR, zero-extended.
- MOC  out  1  memory operation complete, registered.
- ERR  out  1  reserved size code seen; valid while MOC=1.

Behaviour:
- Reset (synchronous, RESET=1 at a rising edge):
  - State goes to IDLE; MOC=0, ERR=0, DATA_OUT=0, wait counter=0.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - At an edge with MOV=1: latch ADDR[ADDR_BITS-1:0], DATA_IN, RW and DS; load the counter with WAIT_STATES; go to WAIT.
  - MOC stays 0 in IDLE.
- WAIT, at each edge:
  - If counter != 0: decrement and stay in WAIT.
  - If counter == 0: perform the access using the latched values, set MOC<=1 (ERR<=1 if DS=11), go to DONE.
- Latency: MOV sampled at edge k gives MOC=1 after edge k+WAIT_STATES+1. With the default of 2, that is 3 cycles.
- DONE:
  - MOC and ERR hold while MOV=1.
  - At an edge with MOV=0: MOC<=0, ERR<=0, go to IDLE.
  - A new request needs MOV low for at least one edge first; there is no back-to-back access without passing through IDLE.
- MOV dropping during WAIT: the access still completes. MOC is high for exactly one cycle (DONE sees MOV=0), then the unit returns to IDLE.
- Inputs changing during WAIT or DONE are ignored; only the values latched in IDLE are used.
- Byte order is little-endian. Alignment is forced by clearing low address bits:
  - Halfword clears bit 0.
  - Word clears bits 1:0.
  - Lanes wrap modulo 2^ADDR_BITS.
- Read:
  - Byte: DATA_OUT={24'b0, mem[a]}.
  - Halfword: {16'b0, mem[a+1], mem[a]}.
  - Word: {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
  - DATA_OUT updates on the access edge and holds until the next completed read. Writes never change DATA_OUT.
- Write:
  - Only the lanes selected by DS are written.
  - Byte writes DATA_IN[7:0]; halfword writes [15:0]; word writes all four.
  - Other bytes are unchanged.
- DS=11 (reserved): no RAM write and no DATA_OUT change; MOC and ERR are asserted normally.
- Reset mid-operation (in WAIT) aborts the access: no write is committed and DATA_OUT is cleared to 0.
- RESET and MOV high at the same edge: reset wins.

Decomposition:
- Shared package holds:
  - DS codes: DS_BYTE=2'b00, DS_HALF=2'b01, DS_WORD=2'b10, DS_RSVD=2'b11.
  - RW_READ=1'b1, RW_WRITE=1'b0.
  - FSM state encodings (2 bits).
- One sub-module is natural: mem_byte_array.
  - 2^ADDR_BITS x 8 storage with four byte lanes.
  - Ports: per-lane write enable and per-lane address.
  - Combinational read of four consecutive wrapped bytes.
- The FSM, alignment and lane-steering logic stay in mem_access_unit.

Test Plan:
- Word write then read: write 0xDEADBEEF to addr 0x10 (RW=0, DS=10), then read addr 0x10 as a word. MOC rises 3 cycles after MOV; DATA_OUT=0xDEADBEEF.
- Byte lanes: after the word write, write byte 0x55 to 0x12, then read word 0x10 -> 0xDE55BEEF. Read byte 0x13 -> 0x000000DE.
- Halfword zero-extend and alignment: read halfword at 0x11 (aligned to 0x10) -> 0x0000BEEF. Read word at 0x13 (aligned to 0x10) -> 0xDE55BEEF.
- Wrap and high bits: word write 0x01020304 to 0xFFFFFFFE; the address uses low 8 bits and aligns to 0xFC. Then read byte 0xFC -> 0x04 and byte 0xFF -> 0x01.
- Handshake: hold MOV=1 for 6 cycles after MOC rises -> MOC stays 1 throughout, then clears one edge after MOV=0. MOV pulsed for 1 cycle -> MOC is a single-cycle pulse at cycle 3.
- Reset and error:
  - Assert RESET one cycle into a word write to 0x20 -> MOC=0, DATA_OUT=0, and a later read of 0x20 returns its old value.
  - A DS=11 request gives MOC=1 with ERR=1 and no RAM or DATA_OUT change.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: size codes, direction codes and FSM states.
package mem_access_unit_pkg;

  localparam logic [1:0] DS_BYTE = 2'b00;
  localparam logic [1:0] DS_HALF = 2'b01;
  localparam logic [1:0] DS_WORD = 2'b10;
  localparam logic [1:0] DS_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Byte lanes touched by an access of the given size; reserved touches none.
  function automatic logic [3:0] lane_mask(input logic [1:0] ds);
    case (ds)
      DS_BYTE: lane_mask = 4'b0001;
      DS_HALF: lane_mask = 4'b0011;
      DS_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Control-word / MAR / MDR bundle between the control unit and the memory access unit.
interface mem_access_unit_if;
  logic        MOV;
  logic        RW;
  logic [1:0]  DS;
  logic [31:0] ADDR;
  logic [31:0] DATA_IN;
  logic [31:0] DATA_OUT;
  logic        MOC;
  logic        ERR;

  modport master (
    output MOV, RW, DS, ADDR, DATA_IN,
    input  DATA_OUT, MOC, ERR
  );

  modport slave (
    input  MOV, RW, DS, ADDR, DATA_IN,
    output DATA_OUT, MOC, ERR
  );
endinterface

// File: rtl/mem_byte_array.sv
// Byte-addressed RAM with four independently addressed lanes: per-lane write, combinational read.
module mem_byte_array #(
  parameter int ADDR_BITS = 8
) (
  input  logic                      CLK,
  input  logic [3:0]                lane_we,
  input  logic [3:0][ADDR_BITS-1:0] lane_addr,
  input  logic [3:0][7:0]           lane_wdata,
  output logic [3:0][7:0]           lane_rdata
);

  logic [7:0] mem [2**ADDR_BITS];

  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (lane_we[i]) mem[lane_addr[i]] <= lane_wdata[i];
    end
  end

  always_comb begin
    lane_rdata = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      lane_rdata[i] = mem[lane_addr[i]];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side partner of the control unit: latches a request, waits WAIT_STATES cycles,
// performs a byte/halfword/word access and holds MOC until MOV is released.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  mem_access_unit_if.slave     bus
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  state_t                    state, state_n;
  logic [CNT_W-1:0]          cnt;
  logic [ADDR_BITS-1:0]      addr_q;
  logic [31:0]               data_q;
  logic                      rw_q;
  logic [1:0]                ds_q;
  logic [31:0]               dout_q;
  logic                      moc_q, err_q;

  logic                      accept, access, release_req;
  logic [ADDR_BITS-1:0]      base;
  logic [3:0][ADDR_BITS-1:0] lane_addr;
  logic [3:0]                lane_we;
  logic [3:0][7:0]           lane_wdata, lane_rdata;
  logic [31:0]               read_val;

  if (ADDR_BITS < 32) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.ADDR[31:ADDR_BITS];
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    access      = 1'b0;
    release_req = 1'b0;
    case (state)
      ST_IDLE: if (bus.MOV) begin
        accept  = 1'b1;
        state_n = ST_WAIT;
      end
      ST_WAIT: if (cnt == '0) begin
        access  = 1'b1;
        state_n = ST_DONE;
      end
      ST_DONE: if (!bus.MOV) begin
        release_req = 1'b1;
        state_n     = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Alignment clears low address bits; lane addresses then wrap naturally at ADDR_BITS.
  always_comb begin
    case (ds_q)
      DS_HALF: base = {addr_q[ADDR_BITS-1:1], 1'b0};
      DS_WORD: base = {addr_q[ADDR_BITS-1:2], 2'b00};
      default: base = addr_q;
    endcase
    lane_addr = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      lane_addr[i] = base + ADDR_BITS'(i);
    end
  end

  // Reset on the access edge must abort the write, hence the RESET gate.
  assign lane_we    = (access && !RESET && rw_q == RW_WRITE) ? lane_mask(ds_q) : 4'b0000;
  assign lane_wdata = data_q;

  always_comb begin
    case (ds_q)
      DS_BYTE: read_val = {24'b0, lane_rdata[0]};
      DS_HALF: read_val = {16'b0, lane_rdata[1], lane_rdata[0]};
      DS_WORD: read_val = lane_rdata;
      default: read_val = '0;
    endcase
  end

  mem_byte_array #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .CLK        (CLK),
    .lane_we    (lane_we),
    .lane_addr  (lane_addr),
    .lane_wdata (lane_wdata),
    .lane_rdata (lane_rdata)
  );

  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q <= bus.ADDR[ADDR_BITS-1:0];
      data_q <= bus.DATA_IN;
      rw_q   <= bus.RW;
      ds_q   <= bus.DS;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt    <= '0;
      moc_q  <= 1'b0;
      err_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      if (accept) cnt <= CNT_W'(WAIT_STATES);
      else if (state == ST_WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (access) begin
        moc_q <= 1'b1;
        err_q <= (ds_q == DS_RSVD);
        if (rw_q == RW_READ && ds_q != DS_RSVD) dout_q <= read_val;
      end
      if (release_req) begin
        moc_q <= 1'b0;
        err_q <= 1'b0;
      end
    end
  end

  assign bus.DATA_OUT = dout_q;
  assign bus.MOC      = moc_q;
  assign bus.ERR      = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random traffic against a byte-array model.
module tb_mem_access_unit;

  localparam int AB    = 8;
  localparam int WS    = 2;
  localparam int DEPTH = 1 << AB;

  logic CLK;
  logic RESET;
  mem_access_unit_if bus();

  mem_access_unit #(.ADDR_BITS(AB), .WAIT_STATES(WS)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mm [DEPTH];
  logic [31:0] model_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned size_bytes(input logic [1:0] ds);
    return (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : 4;
  endfunction

  function automatic int unsigned aligned(input logic [1:0] ds, input logic [31:0] addr);
    int unsigned a = addr % DEPTH;
    return a - (a % size_bytes(ds));
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] ds, input logic [31:0] addr);
    logic [31:0] v = 0;
    int unsigned a = aligned(ds, addr);
    for (int unsigned i = 0; i < size_bytes(ds); i++)
      v = v | (32'(mm[(a + i) % DEPTH]) << (8 * i));
    return v;
  endfunction

  task automatic model_write(input logic [1:0] ds, input logic [31:0] addr, input logic [31:0] d);
    int unsigned a = aligned(ds, addr);
    for (int unsigned i = 0; i < size_bytes(ds); i++)
      mm[(a + i) % DEPTH] = 8'((d >> (8 * i)) & 32'hFF);
  endtask

  // One request: MOV held (or pulsed for one edge), MOC latency/ERR/DATA_OUT checked,
  // then MOC observed high for hold cycles and cleared one edge after MOV drops.
  task automatic do_op(input logic rw, input logic [1:0] ds, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold, input bit pulse);
    int n;
    if (ds != 2'b11) begin
      if (rw) model_dout = model_read(ds, addr);
      else    model_write(ds, addr, wdata);
    end
    @(negedge CLK);
    bus.MOV = 1'b1; bus.RW = rw; bus.DS = ds; bus.ADDR = addr; bus.DATA_IN = wdata;
    @(posedge CLK); #1;
    n = 1;
    @(negedge CLK);
    if (pulse) bus.MOV = 1'b0;
    bus.RW = 1'($urandom); bus.DS = 2'($urandom); bus.ADDR = $urandom; bus.DATA_IN = $urandom;
    while (!bus.MOC && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    check("moc_latency_edges", 32'(n), 32'(WS + 2));
    check("err_at_moc", 32'(bus.ERR), 32'(ds == 2'b11));
    check("dout_at_moc", bus.DATA_OUT, model_dout);
    if (pulse) begin
      @(posedge CLK); #1;
      check("pulse_moc_clear", 32'(bus.MOC), 32'd0);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(posedge CLK); #1;
        check("moc_hold", 32'(bus.MOC), 32'd1);
      end
      @(negedge CLK); bus.MOV = 1'b0;
      @(posedge CLK); #1;
      check("moc_clear", 32'(bus.MOC), 32'd0);
    end
    check("err_clear", 32'(bus.ERR), 32'd0);
    check("dout_hold", bus.DATA_OUT, model_dout);
  endtask

  initial begin
    bus.MOV = 1'b0; bus.RW = 1'b1; bus.DS = 2'b00; bus.ADDR = '0; bus.DATA_IN = '0;
    RESET = 1'b1;
    model_dout = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_moc", 32'(bus.MOC), 32'd0);
    check("reset_err", 32'(bus.ERR), 32'd0);
    check("reset_dout", bus.DATA_OUT, 32'd0);
    @(negedge CLK); RESET = 1'b0;

    // Give every byte a known value.
    for (int unsigned i = 0; i < DEPTH / 4; i++)
      do_op(1'b0, 2'b10, 32'(4 * i), $urandom, 0, 1'b0);

    do_op(1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    do_op(1'b1, 2'b10, 32'h10, 32'h0, 0, 1'b0);
    check("tp_word_rd", bus.DATA_OUT, 32'hDEADBEEF);
    do_op(1'b0, 2'b00, 32'h12, 32'hAAAA_AA55, 0, 1'b0);
    do_op(1'b1, 2'b10, 32'h10, 32'h0, 0, 1'b0);
    check("tp_byte_lane", bus.DATA_OUT, 32'hDE55BEEF);
    do_op(1'b1, 2'b00, 32'h13, 32'h0, 0, 1'b0);
    check("tp_byte_rd", bus.DATA_OUT, 32'h000000DE);
    do_op(1'b1, 2'b01, 32'h11, 32'h0, 0, 1'b0);
    check("tp_half_align", bus.DATA_OUT, 32'h0000BEEF);
    do_op(1'b1, 2'b10, 32'h13, 32'h0, 0, 1'b0);
    check("tp_word_align", bus.DATA_OUT, 32'hDE55BEEF);

    do_op(1'b0, 2'b10, 32'hFFFFFFFE, 32'h01020304, 0, 1'b0);
    do_op(1'b1, 2'b00, 32'hFC, 32'h0, 0, 1'b0);
    check("tp_wrap_lo", bus.DATA_OUT, 32'h00000004);
    do_op(1'b1, 2'b00, 32'hFF, 32'h0, 6, 1'b0);
    check("tp_wrap_hi", bus.DATA_OUT, 32'h00000001);
    do_op(1'b1, 2'b10, 32'h10, 32'h0, 0, 1'b1);

    // Reserved size: ERR, no write, DATA_OUT untouched.
    do_op(1'b0, 2'b11, 32'h10, 32'h12345678, 0, 1'b0);
    do_op(1'b1, 2'b11, 32'h10, 32'h0, 0, 1'b0);
    check("rsvd_keep_dout", bus.DATA_OUT, 32'hDE55BEEF);
    do_op(1'b1, 2'b10, 32'h10, 32'h0, 0, 1'b0);
    check("rsvd_no_write", bus.DATA_OUT, 32'hDE55BEEF);

    // Reset one cycle into a word write to 0x20 aborts it.
    @(negedge CLK);
    bus.MOV = 1'b1; bus.RW = 1'b0; bus.DS = 2'b10; bus.ADDR = 32'h20; bus.DATA_IN = 32'hCAFEF00D;
    @(posedge CLK);
    @(negedge CLK); RESET = 1'b1; bus.MOV = 1'b0;
    @(posedge CLK); #1;
    check("abort_moc", 32'(bus.MOC), 32'd0);
    check("abort_dout", bus.DATA_OUT, 32'd0);
    @(negedge CLK); RESET = 1'b0;
    model_dout = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check("abort_idle_moc", 32'(bus.MOC), 32'd0);
    end
    do_op(1'b1, 2'b10, 32'h20, 32'h0, 0, 1'b0);

    // Reset and MOV high on the same edge: reset wins.
    @(negedge CLK);
    RESET = 1'b1; bus.MOV = 1'b1; bus.RW = 1'b0; bus.DS = 2'b10; bus.ADDR = 32'h30; bus.DATA_IN = 32'h0BADF00D;
    @(posedge CLK);
    @(negedge CLK); RESET = 1'b0; bus.MOV = 1'b0;
    model_dout = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check("rst_wins_moc", 32'(bus.MOC), 32'd0);
    end
    do_op(1'b1, 2'b10, 32'h30, 32'h0, 0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      logic [1:0] ds;
      ds = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_op(1'($urandom), ds, $urandom, $urandom, int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
